// File: rtl/router_dest_fifo_bank.sv
// router_dest_fifo_bank
// Destination-side buffer bank. It holds NUM_CH independent packet FIFOs, one
// for each destination port. Each FIFO has its own valid_out/read_enb/data_out
// handshake. Each channel also tracks packet boundaries (pkt_end). A channel
// whose valid_out stays high without being read for TIMEOUT cycles is flushed.
//
// Ports:
//   clock       system clock, all logic on posedge
//   reset       asynchronous active-high reset, clears all state
//   data_in     write data shared by every channel
//   lfd_state   high when data_in is a packet header byte
//   write_enb   per-channel write strobe
//   read_enb    per-channel read strobe from the destination
//   valid_out   channel i holds at least one entry
//   data_out    registered read data, channel i at [i*DATA_W +: DATA_W]
//   full        channel i holds DEPTH entries
//   empty       channel i holds no entries
//   pkt_end     one-cycle pulse while data_out shows the last byte of a packet
//   soft_reset  one-cycle pulse when channel i has timed out and was flushed
module router_dest_fifo_bank #(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 16,
  parameter int NUM_CH  = 3,
  parameter int TIMEOUT = 30
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     lfd_state,
  input  logic [NUM_CH-1:0]        write_enb,
  input  logic [NUM_CH-1:0]        read_enb,
  output logic [NUM_CH-1:0]        valid_out,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic [NUM_CH-1:0]        full,
  output logic [NUM_CH-1:0]        empty,
  output logic [NUM_CH-1:0]        pkt_end,
  output logic [NUM_CH-1:0]        soft_reset
);

  localparam int ADDR_W = $clog2(NUM_CH);
  localparam int AW     = $clog2(DEPTH);
  localparam int PTR_W  = AW + 1;
  localparam int CNT_W  = DATA_W - ADDR_W + 1;
  localparam int TMO_W  = $clog2(TIMEOUT) + 1;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    logic [DATA_W:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              pkt_end_q, pkt_end_d;
    logic              soft_q, soft_d;
    logic              full_w, empty_w, stall, fire, do_wr, do_rd;
    logic [DATA_W:0]   rd_entry;

    // The extra pointer MSB tells a full FIFO apart from an empty one when the
    // address bits of both pointers are equal.
    assign empty_w  = (wr_ptr_q == rd_ptr_q);
    assign full_w   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign stall    = !empty_w && !read_enb[ch];
    assign fire     = stall && (tmo_q == TMO_W'(TIMEOUT - 1));
    // A write that arrives in the same cycle as a flush is lost.
    assign do_wr    = write_enb[ch] && !full_w && !fire;
    assign do_rd    = read_enb[ch] && !empty_w;
    assign rd_entry = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      dout_d    = dout_q;
      pkt_end_d = 1'b0;
      soft_d    = 1'b0;
      tmo_d     = stall ? tmo_q + TMO_W'(1) : '0;
      if (fire) begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        cnt_d    = '0;
        tmo_d    = '0;
        dout_d   = '0;
        soft_d   = 1'b1;
      end else begin
        if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_rd) begin
          rd_ptr_d = rd_ptr_q + PTR_W'(1);
          dout_d   = rd_entry[DATA_W-1:0];
          // The header carries the payload length above the address field.
          // One is added to the count so that the parity byte is included.
          if (rd_entry[DATA_W]) begin
            cnt_d = CNT_W'(rd_entry[DATA_W-1:ADDR_W]) + CNT_W'(1);
          end else if (cnt_q != '0) begin
            cnt_d     = cnt_q - CNT_W'(1);
            pkt_end_d = (cnt_q == CNT_W'(1));
          end
        end
      end
    end

    // The storage array has no reset. The pointers alone decide which
    // entries are valid.
    always_ff @(posedge clock) begin
      if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= {lfd_state, data_in};
    end

    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        wr_ptr_q  <= '0;
        rd_ptr_q  <= '0;
        cnt_q     <= '0;
        tmo_q     <= '0;
        dout_q    <= '0;
        pkt_end_q <= 1'b0;
        soft_q    <= 1'b0;
      end else begin
        wr_ptr_q  <= wr_ptr_d;
        rd_ptr_q  <= rd_ptr_d;
        cnt_q     <= cnt_d;
        tmo_q     <= tmo_d;
        dout_q    <= dout_d;
        pkt_end_q <= pkt_end_d;
        soft_q    <= soft_d;
      end
    end

    assign valid_out[ch]                  = !empty_w;
    assign empty[ch]                      = empty_w;
    assign full[ch]                       = full_w;
    assign data_out[ch*DATA_W +: DATA_W]  = dout_q;
    assign pkt_end[ch]                    = pkt_end_q;
    assign soft_reset[ch]                 = soft_q;
  end

endmodule

// File: tb/tb_router_dest_fifo_bank.sv
// Testbench for router_dest_fifo_bank. It drives the default 3-channel bank
// with directed and random traffic against a queue-based reference model. A
// second instance (16-bit data, depth 8, 4 channels) is driven with directed
// traffic to cover the wide-parameter case.
module tb_router_dest_fifo_bank;

  localparam int TIMEOUT = 30;
  localparam int DEPTH   = 16;
  localparam int NCH     = 3;
  // Header bytes carry the destination address in their low two bits, so the
  // length field is the header value divided by four.
  localparam int HDR_DIV = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  data_in;
  logic        lfd_state;
  logic [2:0]  write_enb, read_enb;
  logic [2:0]  valid_out, full, empty, pkt_end, soft_reset;
  logic [23:0] data_out;

  logic [15:0] d2_din;
  logic        d2_lfd;
  logic [3:0]  d2_wen, d2_ren;
  logic [3:0]  d2_valid, d2_full, d2_empty, d2_pend, d2_soft;
  logic [63:0] d2_dout;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model state
  logic [8:0] mq [NCH][$];
  int         m_cnt   [NCH];
  int         m_stall [NCH];
  logic [7:0] m_dout  [NCH];
  bit         m_pend  [NCH];
  bit         m_soft  [NCH];

  always #5 clock = ~clock;

  router_dest_fifo_bank dut (
    .clock(clock), .reset(reset), .data_in(data_in), .lfd_state(lfd_state),
    .write_enb(write_enb), .read_enb(read_enb), .valid_out(valid_out),
    .data_out(data_out), .full(full), .empty(empty), .pkt_end(pkt_end),
    .soft_reset(soft_reset)
  );

  router_dest_fifo_bank #(.DATA_W(16), .DEPTH(8), .NUM_CH(4), .TIMEOUT(30)) dut2 (
    .clock(clock), .reset(reset), .data_in(d2_din), .lfd_state(d2_lfd),
    .write_enb(d2_wen), .read_enb(d2_ren), .valid_out(d2_valid),
    .data_out(d2_dout), .full(d2_full), .empty(d2_empty), .pkt_end(d2_pend),
    .soft_reset(d2_soft)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    for (int ch = 0; ch < NCH; ch++) begin
      mq[ch].delete();
      m_cnt[ch] = 0; m_stall[ch] = 0; m_dout[ch] = 8'h00;
      m_pend[ch] = 0; m_soft[ch] = 0;
    end
  endtask

  // Advance the model by one clock edge, using the inputs seen at that edge.
  task automatic modelStep();
    for (int ch = 0; ch < NCH; ch++) begin
      int sz;
      bit stalled;
      logic [8:0] e;
      sz = mq[ch].size();
      m_pend[ch] = 0;
      m_soft[ch] = 0;
      stalled = (sz > 0) && !read_enb[ch];
      if (stalled && m_stall[ch] == TIMEOUT - 1) begin
        mq[ch].delete();
        m_cnt[ch] = 0; m_stall[ch] = 0; m_dout[ch] = 8'h00; m_soft[ch] = 1;
      end else begin
        m_stall[ch] = stalled ? m_stall[ch] + 1 : 0;
        if (read_enb[ch] && sz > 0) begin
          e = mq[ch].pop_front();
          m_dout[ch] = e[7:0];
          if (e[8]) m_cnt[ch] = int'(e[7:0]) / HDR_DIV + 1;
          else if (m_cnt[ch] > 0) begin
            m_cnt[ch]--;
            if (m_cnt[ch] == 0) m_pend[ch] = 1;
          end
        end
        if (write_enb[ch] && sz < DEPTH) mq[ch].push_back({lfd_state, data_in});
      end
    end
  endtask

  task automatic compareAll();
    for (int ch = 0; ch < NCH; ch++) begin
      checkOutput($sformatf("ch%0d valid", ch), valid_out[ch], mq[ch].size() != 0);
      checkOutput($sformatf("ch%0d empty", ch), empty[ch], mq[ch].size() == 0);
      checkOutput($sformatf("ch%0d full", ch), full[ch], mq[ch].size() == DEPTH);
      checkOutput($sformatf("ch%0d dout", ch), data_out[ch*8 +: 8], m_dout[ch]);
      checkOutput($sformatf("ch%0d pkt_end", ch), pkt_end[ch], m_pend[ch]);
      checkOutput($sformatf("ch%0d soft", ch), soft_reset[ch], m_soft[ch]);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] wen, input logic [2:0] ren,
                               input logic lfd, input logic [7:0] din);
    write_enb = wen; read_enb = ren; lfd_state = lfd; data_in = din;
    @(posedge clock);
    modelStep();
    #1;
    compareAll();
  endtask

  task automatic d2Step(input logic [3:0] wen, input logic [3:0] ren,
                        input logic lfd, input logic [15:0] din);
    d2_wen = wen; d2_ren = ren; d2_lfd = lfd; d2_din = din;
    @(posedge clock);
    #1;
  endtask

  logic [7:0]  pkt_bytes [4];
  logic [15:0] d2_bytes  [8];

  initial begin
    pkt_bytes = '{8'h09, 8'hA1, 8'hA2, 8'h5B};
    d2_bytes  = '{16'h0005, 16'hBEEF, 16'h1234, 16'h5000,
                  16'h5001, 16'h5002, 16'h5003, 16'h5004};
    reset = 1'b1;
    write_enb = '0; read_enb = '0; lfd_state = 1'b0; data_in = '0;
    d2_wen = '0; d2_ren = '0; d2_lfd = 1'b0; d2_din = '0;
    modelReset();
    repeat (2) @(posedge clock);
    #1;
    $display("[TB] reset state");
    checkOutput("rst empty", empty, 3'b111);
    checkOutput("rst valid", valid_out, 3'b000);
    checkOutput("rst full", full, 3'b000);
    checkOutput("rst dout", data_out, 24'h0);
    checkOutput("rst pkt_end", pkt_end, 3'b000);
    checkOutput("rst soft", soft_reset, 3'b000);
    checkOutput("rst d2 empty", d2_empty, 4'hF);
    reset = 1'b0;

    // Wide-parameter instance: a header length taken from bits [15:2], full after 8 writes, slice 3
    $display("[TB] parameter sweep instance");
    for (int i = 0; i < 8; i++) begin
      d2Step(4'b1000, 4'b0000, i == 0, d2_bytes[i]);
      checkOutput($sformatf("d2 full w%0d", i), d2_full[3], i == 7);
    end
    for (int i = 0; i < 8; i++) begin
      d2Step(4'b0000, 4'b1000, 1'b0, 16'h0);
      checkOutput($sformatf("d2 dout r%0d", i), d2_dout[63:48], d2_bytes[i]);
      checkOutput($sformatf("d2 pkt_end r%0d", i), d2_pend[3], i == 2);
    end
    d2Step(4'b0000, 4'b0000, 1'b0, 16'h0);
    checkOutput("d2 empty", d2_empty[3], 1'b1);
    checkOutput("d2 other slices", d2_dout[47:0], 48'h0);

    // Asynchronous reset with traffic in flight
    $display("[TB] reset mid-traffic");
    for (int i = 0; i < 5; i++) applyStimulus(3'b001, 3'b000, 1'b0, 8'h21 + 8'(i));
    applyStimulus(3'b000, 3'b001, 1'b0, 8'h00);
    checkOutput("pre-reset dout", data_out[7:0], 8'h21);
    #2 reset = 1'b1;
    #1;
    checkOutput("async empty", empty, 3'b111);
    checkOutput("async valid", valid_out, 3'b000);
    checkOutput("async dout", data_out, 24'h0);
    checkOutput("async full", full, 3'b000);
    modelReset();
    #2 reset = 1'b0;

    // A single packet on channel 1
    $display("[TB] packet on ch1");
    for (int i = 0; i < 4; i++) applyStimulus(3'b010, 3'b000, i == 0, pkt_bytes[i]);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(3'b000, 3'b010, 1'b0, 8'h00);
      checkOutput($sformatf("pkt byte %0d", i), data_out[15:8], pkt_bytes[i]);
      checkOutput($sformatf("pkt end %0d", i), pkt_end[1], i == 3);
    end
    checkOutput("pkt empty after", empty[1], 1'b1);

    // Fill channel 2, overflow, then read and write together while full
    $display("[TB] fill ch2");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(3'b100, 3'b000, 1'b0, 8'h10 + 8'(i));
      checkOutput($sformatf("fill full %0d", i), full[2], i == 15);
    end
    applyStimulus(3'b100, 3'b000, 1'b0, 8'hEE);
    checkOutput("overflow full", full[2], 1'b1);
    applyStimulus(3'b100, 3'b100, 1'b0, 8'hDD);
    checkOutput("rw on full: full", full[2], 1'b0);
    checkOutput("rw on full: dout", data_out[23:16], 8'h10);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(3'b000, 3'b100, 1'b0, 8'h00);
      checkOutput($sformatf("drain %0d", i), data_out[23:16], 8'h11 + 8'(i));
    end
    checkOutput("drain empty", empty[2], 1'b1);

    // Stall on channel 0 until it times out, while channel 1 holds a byte
    $display("[TB] timeout ch0");
    applyStimulus(3'b001, 3'b000, 1'b0, 8'h3C);
    checkOutput("to valid rose", valid_out[0], 1'b1);
    for (int k = 1; k <= 32; k++) begin
      applyStimulus((k == 5) ? 3'b010 : 3'b000, 3'b000, 1'b0, 8'h77);
      checkOutput($sformatf("to soft k%0d", k), soft_reset[0], k == 30);
      if (k == 30) checkOutput("to empty at pulse", empty[0], 1'b1);
      if (k == 31) begin
        checkOutput("to empty after", empty[0], 1'b1);
        checkOutput("to ch1 intact", valid_out[1], 1'b1);
      end
    end
    applyStimulus(3'b000, 3'b010, 1'b0, 8'h00);
    checkOutput("to ch1 data", data_out[15:8], 8'h77);

    // Read that arrives on the last stalled cycle before a timeout
    $display("[TB] timeout cleared");
    applyStimulus(3'b001, 3'b000, 1'b0, 8'h42);
    for (int k = 1; k <= 29; k++) begin
      applyStimulus(3'b000, 3'b000, 1'b0, 8'h00);
      checkOutput($sformatf("tc soft k%0d", k), soft_reset[0], 1'b0);
    end
    applyStimulus(3'b000, 3'b001, 1'b0, 8'h00);
    checkOutput("tc soft at read", soft_reset[0], 1'b0);
    checkOutput("tc data", data_out[7:0], 8'h42);
    checkOutput("tc empty", empty[0], 1'b1);

    // Random traffic. The second phase reads rarely, so channels time out.
    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      logic [2:0] wen, ren;
      int thr;
      thr = (i < 250) ? 6 : 1;
      for (int b = 0; b < 3; b++) begin
        wen[b] = ($urandom_range(0, 9) < 5);
        ren[b] = ($urandom_range(0, 9) < thr);
      end
      applyStimulus(wen, ren, $urandom_range(0, 9) < 2, 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
